// File: rtl/pipe_reg_n.sv
// Parameterised N-stage pipeline register with per-stage valid flags,
// synchronous flush and a registered count of occupied stages.
module pipe_reg_n #(
    parameter int unsigned        WIDTH     = 32,
    parameter int unsigned        DEPTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         E,
    input  logic                         flush,
    input  logic                         valid_in,
    input  logic [WIDTH-1:0]             D,
    output logic [WIDTH-1:0]             Q,
    output logic                         valid_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] data_d  [DEPTH];
    logic             valid_q [DEPTH];
    logic             valid_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Next-state for every stage and the occupancy count; flush beats enable.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i]  = RESET_VAL;
                valid_d[i] = 1'b0;
            end
            count_d = '0;
        end else if (E) begin
            data_d[0]  = D;
            valid_d[0] = valid_in;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            // The last stage's flag leaves the pipe as the new one enters,
            // so the count can never pass DEPTH.
            count_d = count_q + CW'(valid_in) - CW'(valid_q[DEPTH-1]);
        end else begin
            data_d  = data_q;
            valid_d = valid_q;
            count_d = count_q;
        end
    end

    // Stage and count registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= RESET_VAL;
                valid_q[i] <= 1'b0;
            end
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign Q         = data_q[DEPTH-1];
    assign valid_out = valid_q[DEPTH-1];
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule
